// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch controller: FSM state encoding visible on o_state.
// Pure declarations, no logic.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } state_e;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle of stopwatch control outputs toward the BCD counter/display.
// master drives the outputs, slave observes them.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic       countenb;
  logic       countinit;
  logic       latchcount;
  logic [1:0] state;

  modport master (output countenb, output countinit, output latchcount, output state);
  modport slave  (input  countenb, input  countinit, input  latchcount, input  state);

endinterface

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop sync, stability debouncer, registered one-cycle press pulse.
// Press appears DB_CYCLES+3 cycles after a clean edge; a button held through reset must be released first.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    stable  = (cnt_q == CW'(DB_CYCLES - 1)) && (sync2_q == prev_q);

    cnt_d = cnt_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (!stable) begin
      cnt_d = cnt_q + CW'(1);
    end

    level_d = stable ? sync2_q : level_q;
    // Only a proven release arms the press detector, so a level held since reset never fires.
    armed_d = armed_q | (stable & ~sync2_q);
    press_d = stable & sync2_q & ~level_q & armed_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM + 10 ms prescaler driving a downstream BCD counter and display latch.
// State moves one cycle after a debounced press; count pulses are registered, one per TICK_DIV cycles.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 1000000,
  parameter int DB_CYCLES = 500000
) (
  input  logic       i_rtcclk,
  input  logic       i_reset,
  input  logic       i_btn_startstop,
  input  logic       i_btn_lapreset,
  output logic       o_countenb,
  output logic       o_countinit,
  output logic       o_latchcount,
  output logic [1:0] o_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          press_ss, press_lr;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          countenb_q, countenb_d;
  logic          countinit_q, countinit_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk    (i_rtcclk),
    .rst    (i_reset),
    .btn_in (i_btn_startstop),
    .press  (press_ss)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lr (
    .clk    (i_rtcclk),
    .rst    (i_reset),
    .btn_in (i_btn_lapreset),
    .press  (press_lr)
  );

  // startstop is tested first in every state, which discards a simultaneous lapreset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (press_ss) state_d = ST_RUN;
      ST_RUN:  if (press_ss) state_d = ST_STOP; else if (press_lr) state_d = ST_LAP;
      ST_LAP:  if (press_ss) state_d = ST_STOP; else if (press_lr) state_d = ST_RUN;
      ST_STOP: if (press_ss) state_d = ST_RUN;  else if (press_lr) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    presc_d    = presc_q;
    countenb_d = 1'b0;
    unique case (state_q)
      ST_RUN, ST_LAP: begin
        if (presc_q == PW'(TICK_DIV - 1)) begin
          presc_d    = '0;
          countenb_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_IDLE: presc_d = '0;
      default: presc_d = presc_q;
    endcase
    countinit_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
  end

  always_ff @(posedge i_rtcclk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      countenb_q  <= 1'b0;
      countinit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      countenb_q  <= countenb_d;
      countinit_q <= countinit_d;
    end
  end

  assign o_countenb   = countenb_q;
  assign o_countinit  = countinit_q;
  assign o_latchcount = (state_q != ST_LAP);
  assign o_state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DB_CYCLES=4; outputs sampled on the falling edge.
module tb_stopwatch_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic b_ss  = 1'b0;
  logic b_lr  = 1'b0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .i_rtcclk        (clk),
    .i_reset         (rst),
    .i_btn_startstop (b_ss),
    .i_btn_lapreset  (b_lr),
    .o_countenb      (sw_if.countenb),
    .o_countinit     (sw_if.countinit),
    .o_latchcount    (sw_if.latchcount),
    .o_state         (sw_if.state)
  );

  always #5 clk = ~clk;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int last_ce = -1;
  int ce_cnt  = 0;
  int ci_cnt  = 0;
  int ci_at   = -1;
  int overlap = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (sw_if.countenb === 1'b1) begin
      last_ce = cyc;
      ce_cnt++;
    end
    if (sw_if.countinit === 1'b1) begin
      ci_cnt++;
      ci_at = cyc;
    end
    if (sw_if.countenb === 1'b1 && sw_if.countinit === 1'b1) overlap++;
  endtask

  // which: 1 = startstop, 2 = lapreset, 3 = both; at = cycle the expected state first appears
  task automatic press(input int which, input int hold, input int exp_st,
                       input string tag, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    b_ss = ((which & 1) != 0);
    b_lr = ((which & 2) != 0);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == hold) begin
        b_ss = 1'b0;
        b_lr = 1'b0;
      end
      if (!seen && int'(sw_if.state) == exp_st) begin
        seen = 1'b1;
        at   = cyc;
      end
      if (seen && i >= hold) break;
    end
    b_ss = 1'b0;
    b_lr = 1'b0;
    check(tag, int'(sw_if.state), exp_st);
  endtask

  task automatic wait_ce(input int budget, output int at);
    int n0;
    n0 = ce_cnt;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ce_cnt > n0) begin
        at = last_ce;
        break;
      end
    end
    if (at < 0) check("tick_timeout", 0, 1);
  endtask

  initial begin
    int at, p0, lat, r0, c1, c2, c3, c4, c, s, r, n0, ci0;

    repeat (3) step();
    check("rst_state",      int'(sw_if.state), 0);
    check("rst_countenb",   int'(sw_if.countenb), 0);
    check("rst_countinit",  int'(sw_if.countinit), 0);
    check("rst_latchcount", int'(sw_if.latchcount), 1);
    rst = 1'b0;
    repeat (10) step();

    // IDLE -> RUN and the basic 10-cycle cadence
    p0 = cyc;
    press(1, 8, 1, "start_run", r0);
    lat = r0 - p0;
    wait_ce(30, c1);
    check("first_tick", c1 - r0, TD);
    wait_ce(30, c2);
    check("tick_period", c2 - c1, TD);
    check("no_init_in_run", ci_cnt, 0);

    // LAP freezes the display but not the cadence
    press(2, 8, 3, "lap_state", at);
    check("lap_latch", int'(sw_if.latchcount), 0);
    wait_ce(30, c3);
    wait_ce(30, c4);
    check("lap_period", c4 - c3, TD);
    check("lap_cadence", (c3 - c2) % TD, 0);
    check("lap_latch_hold", int'(sw_if.latchcount), 0);
    press(2, 8, 1, "lap_resume", at);
    check("resume_latch", int'(sw_if.latchcount), 1);

    // Stop with the prescaler at 6, hold 50 cycles, resume
    wait_ce(30, c);
    while (cyc < c + 16 - lat) step();
    press(1, 8, 2, "stop_state", s);
    check("stop_presc", s - last_ce, 6);
    n0 = ce_cnt;
    repeat (50) step();
    check("stop_no_tick", ce_cnt - n0, 0);
    check("stop_hold_state", int'(sw_if.state), 2);
    press(1, 8, 1, "restart", r);
    wait_ce(30, c1);
    check("resume_tick", c1 - r, 4);
    wait_ce(30, c2);
    check("resume_period", c2 - c1, TD);

    // STOP -> IDLE issues a single countinit and stops ticking
    press(1, 8, 2, "stop2_state", at);
    ci0 = ci_cnt;
    n0  = ce_cnt;
    press(2, 8, 0, "idle_state", at);
    repeat (100) step();
    check("countinit_once", ci_cnt - ci0, 1);
    check("countinit_at",   ci_at - at, 0);
    check("idle_no_tick",   ce_cnt - n0, 0);
    check("idle_latch",     int'(sw_if.latchcount), 1);

    // Bounces shorter than DB_CYCLES are ignored
    press(1, 8, 1, "run_for_bounce", at);
    for (int k = 0; k < 8; k++) begin
      b_ss = 1'b1; b_lr = 1'b1;
      repeat (3) step();
      b_ss = 1'b0; b_lr = 1'b0;
      repeat (3) step();
    end
    repeat (10) step();
    check("bounce_no_change", int'(sw_if.state), 1);

    // Simultaneous presses: startstop wins
    press(3, 8, 2, "both_stop", at);
    repeat (20) step();
    check("both_stays_stop", int'(sw_if.state), 2);

    // Asynchronous reset mid-RUN
    press(1, 8, 1, "run_again", at);
    repeat (13) step();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state",     int'(sw_if.state), 0);
    check("arst_latch",     int'(sw_if.latchcount), 1);
    check("arst_countenb",  int'(sw_if.countenb), 0);
    check("arst_countinit", int'(sw_if.countinit), 0);
    repeat (3) step();
    rst = 1'b0;
    n0 = ce_cnt;
    repeat (30) step();
    check("post_rst_no_tick", ce_cnt - n0, 0);
    check("post_rst_state",   int'(sw_if.state), 0);

    check("no_enb_with_init", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
